sw_pe_cell: RTL and testbench

//  One processing element of a linear systolic Smith-Waterman array (linear gap).

---
 rtl/sw_pe_cell.sv | 114 +++++++++++
 tb/tb_sw_pe_cell.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sw_pe_cell.sv
// -----------------------------------------------------------------------------
// sw_pe_cell
//   One processing element of a linear systolic Smith-Waterman array using a
//   linear gap penalty. The PE holds one reference base (X_i) and scores the
//   query stream (Y_i) that flows through the array one PE per cycle. Every
//   valid beat computes one DP cell H(i,j) and forwards Y/valid one cycle later.
//   Idle beats (valid_i=0) freeze the DP state, so bubbles are invisible to the
//   alignment result.
//
// Ports
//   clk      in   1   rising-edge clock
//   rst      in   1   synchronous active-low reset (0 = reset)
//   X_i      in   2   reference base of this PE (A/C/G/T = 0..3)
//   Y_i      in   2   query base for this beat
//   valid_i  in   1   qualifies Y_i / top_i
//   top_i    in   SW  H(i-1,j) from the upstream PE (0 for PE0)
//   score_o  out  SW  registered H(i,j) of the last valid beat
//   Y_o      out  2   Y_i delayed one cycle
//   valid_o  out  1   valid_i delayed one cycle
// -----------------------------------------------------------------------------
module sw_pe_cell #(
  parameter int unsigned MATCH    = 32'd2,
  parameter int unsigned MISMATCH = 32'd1,
  parameter int unsigned GAP      = 32'd1,
  parameter int unsigned SW       = 32'd16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    X_i,
  input  logic [1:0]    Y_i,
  input  logic          valid_i,
  input  logic [SW-1:0] top_i,
  output logic [SW-1:0] score_o,
  output logic [1:0]    Y_o,
  output logic          valid_o
);

  // Signed compute width: SW magnitude bits, one bit of headroom for
  // diag+MATCH, one sign bit; never narrower than 18 bits.
  localparam int unsigned CW = (SW + 32'd2 > 32'd18) ? (SW + 32'd2) : 32'd18;

  localparam logic signed [CW-1:0] MATCH_C    = CW'(MATCH);
  localparam logic signed [CW-1:0] MISMATCH_C = CW'(MISMATCH);
  localparam logic signed [CW-1:0] GAP_C      = CW'(GAP);
  localparam logic signed [CW-1:0] ZERO_C     = {CW{1'b0}};
  localparam logic signed [CW-1:0] SAT_C      = {{(CW-SW){1'b0}}, {SW{1'b1}}};

  logic [SW-1:0]          diag_r;
  logic signed [CW-1:0]   d_s;
  logic signed [CW-1:0]   t_s;
  logic signed [CW-1:0]   l_s;
  logic signed [CW-1:0]   best_s;
  logic [SW-1:0]          h_s;

  // Zero-extend an unsigned score into the signed compute width.
  function automatic logic signed [CW-1:0] widen(input logic [SW-1:0] v);
    widen = $signed({{(CW-SW){1'b0}}, v});
  endfunction

  // Candidate scores: diagonal with substitution, top gap, left gap.
  always_comb begin
    d_s = widen(diag_r);
    if (X_i == Y_i) begin
      d_s = d_s + MATCH_C;
    end else begin
      d_s = d_s - MISMATCH_C;
    end
    t_s = widen(top_i) - GAP_C;
    l_s = widen(score_o) - GAP_C;
  end

  // Local-alignment max with floor at zero, then saturate to the SW range.
  always_comb begin
    best_s = ZERO_C;
    if (d_s > best_s) begin
      best_s = d_s;
    end else begin
      best_s = best_s;
    end
    if (t_s > best_s) begin
      best_s = t_s;
    end else begin
      best_s = best_s;
    end
    if (l_s > best_s) begin
      best_s = l_s;
    end else begin
      best_s = best_s;
    end
    if (best_s > SAT_C) begin
      h_s = {SW{1'b1}};
    end else begin
      h_s = best_s[SW-1:0];
    end
  end

  // DP state and pipeline registers; idle beats hold everything but valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      score_o <= {SW{1'b0}};
      diag_r  <= {SW{1'b0}};
      Y_o     <= 2'd0;
      valid_o <= 1'b0;
    end else if (valid_i) begin
      score_o <= h_s;
      diag_r  <= top_i;
      Y_o     <= Y_i;
      valid_o <= 1'b1;
    end else begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sw_pe_cell.sv
// -----------------------------------------------------------------------------
// tb_sw_pe_cell
//   Directed self-checking bench for sw_pe_cell: a single PE under directed
//   beats, plus a 4-PE chain scoring an identical query/reference pair.
// -----------------------------------------------------------------------------
module tb_sw_pe_cell;

  logic        clk;
  logic        rst;
  logic [1:0]  X_i;
  logic [1:0]  Y_i;
  logic        valid_i;
  logic [15:0] top_i;
  logic [15:0] score_o;
  logic [1:0]  Y_o;
  logic        valid_o;

  int total;
  int bad;

  sw_pe_cell #(.MATCH(2), .MISMATCH(1), .GAP(1), .SW(16)) dut (
    .clk(clk), .rst(rst), .X_i(X_i), .Y_i(Y_i), .valid_i(valid_i),
    .top_i(top_i), .score_o(score_o), .Y_o(Y_o), .valid_o(valid_o)
  );

  // 4-PE chain
  logic [1:0]       ch_x [0:3];
  logic [1:0]       ch_y_in;
  logic             ch_v_in;
  logic [4:0][15:0] c_top;
  logic [4:0][1:0]  c_y;
  logic [4:0]       c_v;

  assign c_top[0] = 16'd0;
  assign c_y[0]   = ch_y_in;
  assign c_v[0]   = ch_v_in;

  for (genvar k = 0; k < 4; k++) begin : g_chain
    sw_pe_cell #(.MATCH(2), .MISMATCH(1), .GAP(1), .SW(16)) u_pe (
      .clk(clk), .rst(rst), .X_i(ch_x[k]), .Y_i(c_y[k]), .valid_i(c_v[k]),
      .top_i(c_top[k]), .score_o(c_top[k+1]), .Y_o(c_y[k+1]), .valid_o(c_v[k+1])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [1:0] y, input logic [15:0] t);
    @(negedge clk);
    valid_i = v;
    Y_i     = y;
    top_i   = t;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b0;
    valid_i = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst     = 1'b0;
    valid_i = 1'b1;
    Y_i     = 2'd3;
    top_i   = 16'd7;
    X_i     = 2'd3;
    repeat (3) @(posedge clk);
    #1;
    total++; if (score_o !== 16'd0) begin bad++; $display("FAIL reset_score got=%0d exp=0", score_o); end
    total++; if (valid_o !== 1'b0)  begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    total++; if (Y_o !== 2'd0)      begin bad++; $display("FAIL reset_y got=%0d exp=0", Y_o); end
    @(negedge clk);
    valid_i = 1'b0;
    rst     = 1'b1;
  endtask

  task automatic test_match();
    do_reset();
    X_i = 2'd0;
    drive(1'b1, 2'd0, 16'd0);
    total++; if (score_o !== 16'd2) begin bad++; $display("FAIL match1_score got=%0d exp=2", score_o); end
    total++; if (valid_o !== 1'b1)  begin bad++; $display("FAIL match1_valid got=%b exp=1", valid_o); end
    total++; if (Y_o !== 2'd0)      begin bad++; $display("FAIL match1_y got=%0d exp=0", Y_o); end
    drive(1'b1, 2'd0, 16'd0);
    total++; if (score_o !== 16'd2) begin bad++; $display("FAIL match2_score got=%0d exp=2", score_o); end
    total++; if (valid_o !== 1'b1)  begin bad++; $display("FAIL match2_valid got=%b exp=1", valid_o); end
  endtask

  // Continues from test_match state: score=2, diag=0.
  task automatic test_bubble();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'd3, 16'd100);
      total++; if (valid_o !== 1'b0)  begin bad++; $display("FAIL bubble_valid[%0d] got=%b exp=0", i, valid_o); end
      total++; if (score_o !== 16'd2) begin bad++; $display("FAIL bubble_score[%0d] got=%0d exp=2", i, score_o); end
      total++; if (Y_o !== 2'd0)      begin bad++; $display("FAIL bubble_y[%0d] got=%0d exp=0", i, Y_o); end
    end
    drive(1'b1, 2'd0, 16'd0);
    total++; if (score_o !== 16'd2) begin bad++; $display("FAIL bubble_resume got=%0d exp=2", score_o); end
    total++; if (valid_o !== 1'b1)  begin bad++; $display("FAIL bubble_resume_valid got=%b exp=1", valid_o); end
  endtask

  task automatic test_top_path();
    do_reset();
    X_i = 2'd1;
    drive(1'b1, 2'd2, 16'd5);
    total++; if (score_o !== 16'd4) begin bad++; $display("FAIL top_score got=%0d exp=4", score_o); end
    total++; if (Y_o !== 2'd2)      begin bad++; $display("FAIL top_y got=%0d exp=2", Y_o); end
    drive(1'b1, 2'd1, 16'd0);
    total++; if (score_o !== 16'd7) begin bad++; $display("FAIL diag_score got=%0d exp=7", score_o); end
  endtask

  task automatic test_floor();
    do_reset();
    X_i = 2'd3;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'd0, 16'd0);
      total++; if (score_o !== 16'd0) begin bad++; $display("FAIL floor_score[%0d] got=%0d exp=0", i, score_o); end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    X_i = 2'd0;
    drive(1'b1, 2'd0, 16'hFFFF);
    total++; if (score_o !== 16'hFFFE) begin bad++; $display("FAIL sat1_score got=%h exp=fffe", score_o); end
    drive(1'b1, 2'd0, 16'hFFFF);
    total++; if (score_o !== 16'hFFFF) begin bad++; $display("FAIL sat2_score got=%h exp=ffff", score_o); end
  endtask

  // Reference ACGT vs query ACGT (with one bubble); last PE row is 0,2,5,8.
  task automatic test_chain();
    logic [1:0]  feed_y [0:4];
    logic        feed_v [0:4];
    logic [15:0] exp_s  [0:3];
    int got;
    feed_y = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd3};
    feed_v = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    exp_s  = '{16'd0, 16'd2, 16'd5, 16'd8};
    for (int k = 0; k < 4; k++) ch_x[k] = 2'(k);
    ch_v_in = 1'b0;
    ch_y_in = 2'd0;
    do_reset();
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      @(negedge clk);
      if (c < 5) begin
        ch_v_in = feed_v[c];
        ch_y_in = feed_y[c];
      end else begin
        ch_v_in = 1'b0;
        ch_y_in = 2'd0;
      end
      @(posedge clk);
      #1;
      if (c_v[4] === 1'b1) begin
        total++;
        if (c_top[4] !== exp_s[got]) begin
          bad++;
          $display("FAIL chain_score[%0d] got=%0d exp=%0d", got, c_top[4], exp_s[got]);
        end
        got++;
      end
    end
    total++;
    if (got != 4) begin bad++; $display("FAIL chain_timeout got=%0d outputs exp=4", got); end
    @(negedge clk);
    ch_v_in = 1'b0;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b0;
    valid_i = 1'b0;
    Y_i     = 2'd0;
    top_i   = 16'd0;
    X_i     = 2'd0;
    ch_v_in = 1'b0;
    ch_y_in = 2'd0;
    for (int k = 0; k < 4; k++) ch_x[k] = 2'd0;
    test_reset();
    test_match();
    test_bubble();
    test_top_path();
    test_floor();
    test_saturate();
    test_chain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
